// File: rtl/backup_sync.sv
// ---------------------------------------------------------------------------
// backup_sync
//   Backup-RAM transfer sequencer. Moves a runtime-selectable number of
//   sectors between the hps_io SD sector interface and a backup region in
//   SDRAM, staged through an external one-sector dual-port buffer (port A).
//     load : SD -> buffer (SD_RD), then buffer -> SDRAM (LD_XFER), per sector
//     save : SDRAM -> buffer (SV_XFER), then buffer -> SD (SD_WR), per sector
//   Also tracks dirty state so that opening the OSD can trigger an autosave.
//
// Ports
//   clk_sys, reset_n        clock, async active-low reset (sync release)
//   enable                  image mounted and writable; gates new requests
//   sector_count            sectors per transfer (0..2^SEC_W), sampled at start
//   load_req / save_req     rising edge starts a load / save
//   autosave, osd_open      autosave mode; OSD visible (rising edge = trigger)
//   dirty_set               core wrote into the backup region
//   sd_lba, sd_rd, sd_wr    SD sector request; sd_ack marks transfer active
//   mem_addr/req/rnw/ack    one SDRAM channel, {sector, word} addressing
//   buf_addr, buf_we        buffer port-A address and write strobe
//   busy, loading, pending  status; done pulses when a transfer completes
// ---------------------------------------------------------------------------
module backup_sync #(
    parameter int SEC_W  = 8,
    parameter int WORD_W = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [SEC_W:0]          sector_count,
    input  logic                    load_req,
    input  logic                    save_req,
    input  logic                    autosave,
    input  logic                    osd_open,
    input  logic                    dirty_set,
    output logic [31:0]             sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    output logic [SEC_W+WORD_W-1:0] mem_addr,
    output logic                    mem_req,
    output logic                    mem_rnw,
    input  logic                    mem_ack,
    output logic [WORD_W-1:0]       buf_addr,
    output logic                    buf_we,
    output logic                    busy,
    output logic                    loading,
    output logic                    pending,
    output logic                    done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SD_RD, ST_LD_XFER, ST_SV_XFER, ST_SD_WR, ST_NEXT
    } state_e;

    // Per-word handshake inside LD_XFER / SV_XFER: present the address for
    // one cycle (buffer read latency), pulse mem_req, then wait for mem_ack.
    typedef enum logic [1:0] {PH_SETUP, PH_REQ, PH_WAIT} phase_e;

    // Reset: assertion is immediate, release is synchronised to clk_sys.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SEC_W-1:0]    sector_q, sector_d;
    logic [SEC_W:0]      count_q, count_d;
    logic                loading_q, loading_d;
    logic                pending_q, pending_d;
    logic                ack_seen_q, ack_seen_d;
    logic [2:0]          req_q, req_prev_q;     // {osd_open, save_req, load_req}

    logic load_edge, save_edge, auto_trig, save_start, last_sector;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_SETUP;
            word_q     <= '0;
            sector_q   <= '0;
            count_q    <= '0;
            loading_q  <= 1'b0;
            pending_q  <= 1'b0;
            ack_seen_q <= 1'b0;
            req_q      <= '0;
            req_prev_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its neighbours.
            state_q    <= state_d;
            phase_q    <= phase_d;
            word_q     <= word_d;
            sector_q   <= sector_d;
            count_q    <= count_d;
            loading_q  <= loading_d;
            pending_q  <= pending_d;
            ack_seen_q <= ack_seen_d;
            req_q      <= {osd_open, save_req, load_req};
            req_prev_q <= req_q;
        end
    end

    assign load_edge = req_q[0] & ~req_prev_q[0];
    assign save_edge = req_q[1] & ~req_prev_q[1];
    assign auto_trig = req_q[2] & ~req_prev_q[2] & pending_q & autosave;

    // count==0 finishes on the first NEXT visit without touching SD or SDRAM.
    assign last_sector = (count_q == '0) ||
                         ({1'b0, sector_q} == count_q - (SEC_W+1)'(1));

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        word_d     = word_q;
        sector_d   = sector_q;
        count_d    = count_q;
        loading_d  = loading_q;
        ack_seen_d = ack_seen_q;
        pending_d  = pending_q;
        save_start = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && (load_edge || save_edge || auto_trig)) begin
                    count_d    = sector_count;
                    sector_d   = '0;
                    word_d     = '0;
                    phase_d    = PH_SETUP;
                    ack_seen_d = 1'b0;
                    loading_d  = load_edge;          // load wins a tie
                    save_start = ~load_edge;
                    if (sector_count == '0) state_d = ST_NEXT;
                    else if (load_edge)     state_d = ST_SD_RD;
                    else                    state_d = ST_SV_XFER;
                end
            end
            ST_SD_RD, ST_SD_WR: begin
                // Request drops once ack is seen; move on when ack falls.
                if (sd_ack) begin
                    ack_seen_d = 1'b1;
                end else if (ack_seen_q) begin
                    ack_seen_d = 1'b0;
                    state_d    = (state_q == ST_SD_RD) ? ST_LD_XFER : ST_NEXT;
                end
            end
            ST_LD_XFER, ST_SV_XFER: begin
                case (phase_q)
                    PH_SETUP: phase_d = PH_REQ;
                    PH_REQ:   phase_d = PH_WAIT;
                    PH_WAIT: begin
                        if (mem_ack) begin
                            word_d  = word_q + WORD_W'(1);   // wraps to 0 after last word
                            phase_d = PH_SETUP;
                            if (&word_q)
                                state_d = (state_q == ST_LD_XFER) ? ST_NEXT : ST_SD_WR;
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
            ST_NEXT: begin
                state_d  = ST_IDLE;
                sector_d = '0;
                if (enable) begin
                    if (last_sector) begin
                        done = 1'b1;
                        if (loading_q) pending_d = 1'b0;
                    end else begin
                        sector_d = sector_q + SEC_W'(1);
                        state_d  = loading_q ? ST_SD_RD : ST_SV_XFER;
                    end
                end
                // enable low: the sector just finished, abort without done.
            end
            default: state_d = ST_IDLE;
        endcase

        // A save clears the dirty flag as it starts; a write in that same
        // cycle (or later) marks the image dirty again.
        if (save_start) pending_d = 1'b0;
        if (dirty_set && enable && !osd_open) pending_d = 1'b1;
    end

    assign busy     = (state_q != ST_IDLE);
    assign loading  = loading_q;
    assign pending  = pending_q;
    assign sd_rd    = (state_q == ST_SD_RD) && !ack_seen_q;
    assign sd_wr    = (state_q == ST_SD_WR) && !ack_seen_q;
    assign sd_lba   = {{(32-SEC_W){1'b0}}, sector_q};
    assign buf_addr = word_q;
    assign mem_addr = {sector_q, word_q};
    assign mem_req  = ((state_q == ST_LD_XFER) || (state_q == ST_SV_XFER)) &&
                      (phase_q == PH_REQ);
    assign mem_rnw  = busy && !loading_q;
    assign buf_we   = (state_q == ST_SV_XFER) && (phase_q == PH_WAIT) && mem_ack;

endmodule

// File: tb/tb_backup_sync.sv
// ---------------------------------------------------------------------------
// tb_backup_sync
//   Directed bench for backup_sync. SD and SDRAM responders model the
//   handshakes; expected SD requests, SDRAM accesses and buffer writes are
//   queued when stimulus is issued and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_backup_sync;

    localparam int SEC_W  = 8;
    localparam int WORD_W = 8;
    localparam int NWORDS = 1 << WORD_W;

    logic                    clk_sys = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    enable = 1'b0;
    logic [SEC_W:0]          sector_count = '0;
    logic                    load_req = 1'b0;
    logic                    save_req = 1'b0;
    logic                    autosave = 1'b0;
    logic                    osd_open = 1'b0;
    logic                    dirty_set = 1'b0;
    logic [31:0]             sd_lba;
    logic                    sd_rd;
    logic                    sd_wr;
    logic                    sd_ack = 1'b0;
    logic [SEC_W+WORD_W-1:0] mem_addr;
    logic                    mem_req;
    logic                    mem_rnw;
    logic                    mem_ack = 1'b0;
    logic [WORD_W-1:0]       buf_addr;
    logic                    buf_we;
    logic                    busy;
    logic                    loading;
    logic                    pending;
    logic                    done;

    backup_sync #(.SEC_W(SEC_W), .WORD_W(WORD_W)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
        .sector_count(sector_count), .load_req(load_req), .save_req(save_req),
        .autosave(autosave), .osd_open(osd_open), .dirty_set(dirty_set),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_rnw(mem_rnw),
        .mem_ack(mem_ack), .buf_addr(buf_addr), .buf_we(buf_we),
        .busy(busy), .loading(loading), .pending(pending), .done(done)
    );

    initial forever #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        rnw;
        logic [15:0] addr;
    } mem_exp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
    } sd_exp_t;

    mem_exp_t          exp_mem_q[$];
    sd_exp_t           exp_sd_q[$];
    logic [WORD_W-1:0] exp_we_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int mem_req_cnt = 0;
    int sd_rise_cnt = 0;
    logic sd_rd_prev = 1'b0;
    logic sd_wr_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sd_lba"}, 64'(sd_lba), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_buf_addr"}, 64'(buf_addr), 64'd0);
        check({tag, "_ctrl"}, 64'({sd_rd, sd_wr, mem_req, mem_rnw, buf_we,
                                    busy, loading, pending, done}), 64'd0);
    endtask

    task automatic push_load(input int sec);
        exp_sd_q.push_back('{wr: 1'b0, lba: 32'(sec)});
        for (int w = 0; w < NWORDS; w++)
            exp_mem_q.push_back('{rnw: 1'b0, addr: 16'((sec << WORD_W) | w)});
    endtask

    task automatic push_save(input int sec);
        for (int w = 0; w < NWORDS; w++) begin
            exp_mem_q.push_back('{rnw: 1'b1, addr: 16'((sec << WORD_W) | w)});
            exp_we_q.push_back(WORD_W'(w));
        end
        exp_sd_q.push_back('{wr: 1'b1, lba: 32'(sec)});
    endtask

    task automatic pulse(input logic ld, input logic sv);
        @(negedge clk_sys);
        load_req = ld;
        save_req = sv;
        repeat (2) @(negedge clk_sys);
        load_req = 1'b0;
        save_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (busy === 1'b1 && n < max_cyc) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_mem_left"}, 64'(exp_mem_q.size()), 64'd0);
        check({tag, "_sd_left"}, 64'(exp_sd_q.size()), 64'd0);
        check({tag, "_we_left"}, 64'(exp_we_q.size()), 64'd0);
    endtask

    // SDRAM responder: one-cycle ack in the cycle after the request.
    initial forever begin
        @(negedge clk_sys);
        if (mem_req === 1'b1) begin
            @(negedge clk_sys);
            mem_ack = 1'b1;
            @(negedge clk_sys);
            mem_ack = 1'b0;
        end
    end

    // SD responder: ack rises 2 cycles after a request and lasts 10 cycles.
    initial forever begin
        @(negedge clk_sys);
        if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
            repeat (2) @(negedge clk_sys);
            sd_ack = 1'b1;
            repeat (10) @(negedge clk_sys);
            sd_ack = 1'b0;
        end
    end

    // Monitor / scoreboard, sampling mid-low-phase after responders settle.
    initial forever begin
        mem_exp_t me;
        sd_exp_t  se;
        @(negedge clk_sys);
        #2;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cyc++;
        if (mem_req === 1'b1) mem_req_cnt++;

        if (exp_mem_q.size() == 0) begin
            check("mem_req_unexpected", 64'(mem_req), 64'd0);
        end else if (mem_req === 1'b1) begin
            me = exp_mem_q.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(me.addr));
            check("mem_rnw", 64'(mem_rnw), 64'(me.rnw));
        end

        if (exp_we_q.size() == 0) begin
            check("buf_we_unexpected", 64'(buf_we), 64'd0);
        end else if (buf_we === 1'b1) begin
            check("buf_we_addr", 64'(buf_addr), 64'(exp_we_q.pop_front()));
        end

        if ((sd_rd === 1'b1 && !sd_rd_prev) || (sd_wr === 1'b1 && !sd_wr_prev)) begin
            sd_rise_cnt++;
            if (exp_sd_q.size() == 0) begin
                check("sd_req_unexpected", 64'({sd_rd, sd_wr}), 64'd0);
            end else begin
                se = exp_sd_q.pop_front();
                check("sd_dir_wr", 64'(sd_wr), 64'(se.wr));
                check("sd_lba", 64'(sd_lba), 64'(se.lba));
            end
        end
        sd_rd_prev = sd_rd;
        sd_wr_prev = sd_wr;
    end

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int b0;
        int m0;
        int s0;
        int n;

        // Reset state.
        repeat (3) @(negedge clk_sys);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check_all_zero("after_release");
        enable = 1'b1;

        // Load, two sectors.
        sector_count = 9'd2;
        push_load(0);
        push_load(1);
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        check("load2_loading", 64'(loading), 64'd1);
        wait_idle("load2_idle", 4000);
        repeat (5) @(negedge clk_sys);
        check("load2_done_once", 64'(done_cnt - d0), 64'd1);
        check_queues("load2");

        // Save, one sector.
        sector_count = 9'd1;
        push_save(0);
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        check("save1_loading", 64'(loading), 64'd0);
        wait_idle("save1_idle", 3000);
        repeat (5) @(negedge clk_sys);
        check("save1_done_once", 64'(done_cnt - d0), 64'd1);
        check_queues("save1");

        // Autosave on OSD open while dirty.
        autosave = 1'b1;
        @(negedge clk_sys); dirty_set = 1'b1;
        @(negedge clk_sys); dirty_set = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("dirty_pending_set", 64'(pending), 64'd1);
        push_save(0);
        d0 = done_cnt;
        @(negedge clk_sys); osd_open = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        check("autosave_started", 64'(busy), 64'd1);
        check("autosave_pending_clr", 64'(pending), 64'd0);
        wait_idle("autosave_idle", 3000);
        check("autosave_done", 64'(done_cnt - d0), 64'd1);
        check_queues("autosave");
        osd_open = 1'b0;

        // Autosave disabled: OSD open does nothing.
        autosave = 1'b0;
        @(negedge clk_sys); dirty_set = 1'b1;
        @(negedge clk_sys); dirty_set = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("dirty_pending_set2", 64'(pending), 64'd1);
        b0 = busy_cyc;
        @(negedge clk_sys); osd_open = 1'b1;
        repeat (10) @(negedge clk_sys);
        check("no_autosave_busy", 64'(busy_cyc - b0), 64'd0);
        check("no_autosave_pending", 64'(pending), 64'd1);
        osd_open = 1'b0;

        // save_req during an active load is discarded; load clears pending.
        push_load(0);
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        repeat (30) @(negedge clk_sys);
        check("load_busy_mid", 64'(busy), 64'd1);
        pulse(1'b0, 1'b1);
        wait_idle("load_vs_save_idle", 3000);
        repeat (5) @(negedge clk_sys);
        check("load_vs_save_done", 64'(done_cnt - d0), 64'd1);
        check("load_clears_pending", 64'(pending), 64'd0);
        check_queues("load_vs_save");

        // Simultaneous edges: load wins.
        push_load(0);
        d0 = done_cnt;
        pulse(1'b1, 1'b1);
        check("simul_loading", 64'(loading), 64'd1);
        check("simul_rnw", 64'(mem_rnw), 64'd0);
        wait_idle("simul_idle", 3000);
        check("simul_done", 64'(done_cnt - d0), 64'd1);
        check_queues("simul");

        // Reset in the middle of LD_XFER.
        sector_count = 9'd2;
        push_load(0);
        push_load(1);
        m0 = mem_req_cnt;
        pulse(1'b1, 1'b0);
        n = 0;
        while ((mem_req_cnt - m0) < 10 && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check("rst_mid_in_xfer", 64'((mem_req_cnt - m0) >= 10), 64'd1);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_mem_q.delete();
        exp_sd_q.delete();
        exp_we_q.delete();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        sector_count = 9'd1;
        push_load(0);
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        wait_idle("rst_restart_idle", 3000);
        check("rst_restart_done", 64'(done_cnt - d0), 64'd1);
        check_queues("rst_restart");

        // sector_count == 0: done one cycle after start, no SD/mem traffic.
        sector_count = '0;
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            b0 = busy_cyc;
            m0 = mem_req_cnt;
            s0 = sd_rise_cnt;
            pulse(k == 0, k == 1);
            repeat (4) @(negedge clk_sys);
            check("zero_done", 64'(done_cnt - d0), 64'd1);
            check("zero_busy_cycles", 64'(busy_cyc - b0), 64'd1);
            check("zero_mem_reqs", 64'(mem_req_cnt - m0), 64'd0);
            check("zero_sd_reqs", 64'(sd_rise_cnt - s0), 64'd0);
        end

        // enable falls mid-sector: sector completes, no done, no sector 1.
        sector_count = 9'd2;
        push_load(0);
        d0 = done_cnt;
        m0 = mem_req_cnt;
        pulse(1'b1, 1'b0);
        n = 0;
        while ((mem_req_cnt - m0) < 20 && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check("en_low_in_xfer", 64'((mem_req_cnt - m0) >= 20), 64'd1);
        enable = 1'b0;
        wait_idle("en_low_idle", 3000);
        repeat (20) @(negedge clk_sys);
        check("en_low_no_done", 64'(done_cnt - d0), 64'd0);
        check("en_low_words", 64'(mem_req_cnt - m0), 64'(NWORDS));
        check_queues("en_low");
        enable = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
